ram_be_pipe: RTL and testbench



---
 rtl/ram_be_pipe.sv | 116 +++++++++++
 tb/tb_ram_be_pipe.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ram_be_pipe.sv
// ram_be_pipe: single-clock RAM, one write + one read port, byte-lane write enables,
// 1- or 2-stage registered read path with valid strobe, and a hardware clear engine.
// Optional feature macro: RAM_BYPASS_EN (forward same-cycle, same-address write lanes to the read).
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   cs                     chip select gating every request
//   wen, wbe, waddr, wdata write request, byte-lane enables, address, data
//   ren, raddr             read request and address
//   clr                    pulse that restarts the clear engine
//   rdata, rvalid          registered read data (held between reads) and its one-cycle strobe
//   init_busy              high while the clear engine zeroes the array
//   err                    sticky out-of-range access flag, cleared only by rst
module ram_be_pipe #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cs,
   input  logic                    wen,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    ren,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   input  logic                    clr,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    rvalid,
   output logic                    init_busy,
   output logic                    err
);
   localparam int NB = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("ram_be_pipe: RD_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("ram_be_pipe: DATA_WIDTH must be a multiple of 8");
   end
   typedef enum logic {INIT, READY} state_e;
   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   rd_word, d1_q;
   logic                    v1_q, err_q, wr_acc, rd_acc, w_ok, r_ok;
   // clr in READY takes priority over any same-cycle request
   assign wr_acc    = state_q == READY && cs && wen && !clr;
   assign rd_acc    = state_q == READY && cs && ren && !clr;
   assign w_ok      = {1'b0, waddr} < DEPTH_W;
   assign r_ok      = {1'b0, raddr} < DEPTH_W;
   assign init_busy = state_q == INIT;
   assign err       = err_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         state_d = cnt_q == LAST ? READY : INIT;
         cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      end else if (clr) begin
         state_d = INIT;
         cnt_d   = '0;
      end
   end
   // Out-of-range reads return zero; the optional bypass overlays written lanes
   always_comb begin
      rd_word = r_ok ? mem[raddr] : '0;
`ifdef RAM_BYPASS_EN
      for (int b = 0; b < NB; b++)
         if (wr_acc && w_ok && waddr == raddr && wbe[b]) rd_word[8*b +: 8] = wdata[8*b +: 8];
`else
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         v1_q    <= 1'b0;
         d1_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         v1_q    <= rd_acc;
         if (rd_acc) d1_q <= rd_word;
         if ((wr_acc && !w_ok) || (rd_acc && !r_ok)) err_q <= 1'b1;
      end
   end
   // The array itself carries no reset; the clear engine zeroes it word by word
   always_ff @(posedge clk) begin
      if (state_q == INIT) mem[cnt_q] <= '0;
      else if (wr_acc && w_ok)
         for (int b = 0; b < NB; b++)
            if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
   end
   if (RD_LATENCY == 2) begin : g_lat2
      logic                  v2_q;
      logic [DATA_WIDTH-1:0] d2_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) d2_q <= d1_q;
         end
      end
      assign rvalid = v2_q;
      assign rdata  = d2_q;
   end else begin : g_lat1
      assign rvalid = v1_q;
      assign rdata  = d1_q;
   end
endmodule

// File: tb/tb_ram_be_pipe.sv
// tb_ram_be_pipe: directed bench driving a 16-word 2-cycle RAM and a 12-word 1-cycle RAM in lockstep.
module tb_ram_be_pipe;
   logic        clk, rst, cs, wen, ren, clr;
   logic [3:0]  wbe, waddr, raddr;
   logic [31:0] wdata, rdata1, rdata2;
   logic        rvalid1, rvalid2, busy1, busy2, err1, err2;
   logic [31:0] exp1 [16];
   logic [31:0] exp2 [16];
   int          n_chk = 0, n_fail = 0, c1, c2, rv;
`ifdef RAM_BYPASS_EN
   localparam logic [31:0] RDW_EXP = 32'hDEADBEEF;
`else
   localparam logic [31:0] RDW_EXP = 32'h00000000;
`endif
   ram_be_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .RD_LATENCY(2)) u_d16 (
      .clk(clk), .rst(rst), .cs(cs), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .clr(clr), .rdata(rdata1), .rvalid(rvalid1),
      .init_busy(busy1), .err(err1));
   ram_be_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .RD_LATENCY(1)) u_d12 (
      .clk(clk), .rst(rst), .cs(cs), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .clr(clr), .rdata(rdata2), .rvalid(rvalid2),
      .init_busy(busy2), .err(err2));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic idle;
      cs = 0; wen = 0; ren = 0; clr = 0; wbe = 0; waddr = 0; raddr = 0; wdata = 0;
   endtask
   // Reads addresses 0..n-1 back to back; the 12-word RAM answers after the accepting edge,
   // the 16-word RAM one edge later.
   task automatic rd_seq(input int n);
      for (int k = 0; k < n + 2; k++) begin
         cs = 1; wen = 0; ren = k < n; raddr = 4'(k);
         tick;
         chk("rvalid_l2", rvalid1, k >= 1 && k < n + 1);
         if (k >= 1 && k < n + 1) chk($sformatf("rdata_l2[%0d]", k - 1), rdata1, exp1[k-1]);
         chk("rvalid_l1", rvalid2, k < n);
         if (k < n) chk($sformatf("rdata_l1[%0d]", k), rdata2, exp2[k]);
      end
      idle;
   endtask
   initial begin
      for (int i = 0; i < 16; i++) begin exp1[i] = '0; exp2[i] = '0; end
      idle;
      rst = 1;
      #1;
      chk("rst_busy16", busy1, 1);
      chk("rst_busy12", busy2, 1);
      chk("rst_rvalid", {rvalid1, rvalid2}, 0);
      chk("rst_rdata", rdata1 | rdata2, 0);
      chk("rst_err", {err1, err2}, 0);
      tick;
      rst = 0;
      c1 = 0; c2 = 0; rv = 0;
      for (int i = 0; i < 30; i++) begin
         if (busy1) c1++;
         if (busy2) c2++;
         if (rvalid1 || rvalid2) rv++;
         if (i < 12) begin
            cs = 1; wen = 1; wbe = 4'hF; waddr = i < 6 ? 4'd13 : 4'd3; wdata = 32'hFFFFFFFF;
            ren = 1; raddr = 4'd14;
         end else idle;
         tick;
      end
      chk("init_cycles16", c1, 16);
      chk("init_cycles12", c2, 12);
      chk("init_no_rvalid", rv, 0);
      chk("init_no_err", {err1, err2}, 0);
      rd_seq(12);
      cs = 1; wen = 1; waddr = 3; wdata = 32'hAABBCCDD; wbe = 4'b1111;
      tick;
      wdata = 32'h11223344; wbe = 4'b0101;
      tick;
      wdata = 32'hFFFFFFFF; wbe = 4'b0000;
      tick;
      wen = 0; ren = 1; raddr = 3;
      tick;
      chk("be_rvalid_l1", rvalid2, 1);
      chk("be_rdata_l1", rdata2, 32'hAA22CC44);
      chk("be_early_l2", rvalid1, 0);
      ren = 0;
      tick;
      chk("be_rvalid_l2", rvalid1, 1);
      chk("be_rdata_l2", rdata1, 32'hAA22CC44);
      chk("be_pulse_l1", rvalid2, 0);
      chk("be_hold_l1", rdata2, 32'hAA22CC44);
      wen = 1; waddr = 5; wdata = 32'hDEADBEEF; wbe = 4'hF; ren = 1; raddr = 5;
      tick;
      idle;
      chk("rdw_l1", rdata2, RDW_EXP);
      tick;
      chk("rdw_l2", rdata1, RDW_EXP);
      chk("no_err_yet", {err1, err2}, 0);
      for (int k = 0; k < 16; k++) begin
         cs = 1; wen = 1; wbe = 4'hF; waddr = 4'(k); wdata = 32'hC0DE0000 | k;
         tick;
         exp1[k] = 32'hC0DE0000 | k;
         exp2[k] = k < 12 ? 32'hC0DE0000 | k : 32'h0;
      end
      idle;
      chk("oor_write_err12", err2, 1);
      chk("inrange_err16", err1, 0);
      rd_seq(16);
      cs = 1; ren = 1; raddr = 4;
      tick;
      chk("pre_clr_rd_l1", rdata2, 32'hC0DE0004);
      clr = 1; wen = 1; waddr = 2; wdata = 32'hFFFFFFFF; wbe = 4'hF; raddr = 7;
      tick;
      idle;
      chk("clr_inflight_v_l2", rvalid1, 1);
      chk("clr_inflight_d_l2", rdata1, 32'hC0DE0004);
      chk("clr_drop_rd_l1", rvalid2, 0);
      chk("clr_busy", {busy1, busy2}, 2'b11);
      c1 = 0; c2 = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy1) c1++;
         if (busy2) c2++;
         tick;
         if (i == 0) chk("clr_drop_rd_l2", rvalid1, 0);
      end
      chk("clr_cycles16", c1, 16);
      chk("clr_cycles12", c2, 12);
      for (int i = 0; i < 16; i++) begin exp1[i] = '0; exp2[i] = '0; end
      rd_seq(16);
      chk("err_sticky12", err2, 1);
      chk("err_clean16", err1, 0);
      #2;
      rst = 1;
      #1;
      chk("async_err_clr", err2, 0);
      chk("async_busy", {busy1, busy2}, 2'b11);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
